muldiv_wb_unit: RTL and testbench

- Iterative 32-bit unsigned multiply/divide unit for the miniRISC datapath.
- Takes two register-file read operands (rs, rt) plus a destination register address.
- Runs a 32-step shift-add multiply or restoring divide.
- Delivers the result on a one-cycle write-back port (address, data, enable) that drives the register file write port directly.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_wb_unit.sv | 110 +++++++++++
 tb/tb_muldiv_wb_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide write-back unit.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW    = 5;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             isDiv,
    input  logic [WIDTH:0]   hiIn,
    input  logic [WIDTH-1:0] loIn,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   hiOut,
    output logic [WIDTH-1:0] loOut
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;

    always_comb begin
        // hiIn[WIDTH] is always 0 while multiplying, so the add keeps its carry in sum[WIDTH]
        sum     = hiIn + (loIn[0] ? {1'b0, operand} : '0);
        shifted = {hiIn[WIDTH-1:0], loIn[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};
        hiOut   = {1'b0, sum[WIDTH:1]};
        loOut   = {sum[0], loIn[WIDTH-1:1]};
        if (isDiv) begin
            if (!diff[WIDTH+1]) begin
                hiOut = diff[WIDTH:0];
                loOut = {loIn[WIDTH-2:0], 1'b1};
            end else begin
                hiOut = shifted;
                loOut = {loIn[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_wb_unit.sv
// Iterative unsigned MUL/MULH/DIV/REM unit with a registered one-cycle
// register-file write-back port.
module muldiv_wb_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int AW    = DEF_AW,
    parameter int CW    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [AW-1:0]    rd,
    input  logic             kill,
    output logic             busy,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [WIDTH-1:0] wr_data
);

    state_t           state, stateNext;
    logic [CW-1:0]    cnt;
    logic [1:0]       opR;
    logic [AW-1:0]    rdR;
    logic [WIDTH:0]   hiR, hiNext;
    logic [WIDTH-1:0] loR, loNext;
    logic [WIDTH-1:0] opndR;
    logic             lastIter;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .isDiv   (opR[1]),
        .hiIn    (hiR),
        .loIn    (loR),
        .operand (opndR),
        .hiOut   (hiNext),
        .loOut   (loNext)
    );

    assign lastIter = (cnt == CW'(WIDTH - 1));
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE: if (start) stateNext = S_RUN;
            S_RUN: begin
                if (kill)          stateNext = S_IDLE;
                else if (lastIter) stateNext = S_DONE;
            end
            S_DONE:  stateNext = S_IDLE;
            default: stateNext = S_IDLE;
        endcase
    end

    // Multiply keeps the multiplier in lo and adds the multiplicand;
    // divide shifts the dividend out of lo and trial-subtracts the divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            opR   <= '0;
            rdR   <= '0;
            hiR   <= '0;
            loR   <= '0;
            opndR <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= '0;
                        opR   <= op;
                        rdR   <= rd;
                        hiR   <= '0;
                        loR   <= op[1] ? a : b;
                        opndR <= op[1] ? b : a;
                    end
                end
                S_RUN: begin
                    hiR <= hiNext;
                    loR <= loNext;
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // op[0] selects the upper half (MULH) or the remainder (REM).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= (state == S_DONE);
            if (state == S_DONE) begin
                wr_addr <= rdR;
                wr_data <= opR[0] ? hiR[WIDTH-1:0] : loR;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Scoreboard bench for muldiv_wb_unit: directed ops, latency, handshake, kill and reset.
module tb_muldiv_wb_unit;
    import muldiv_pkg::*;

    logic        clk, rst, start, kill;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic        busy, wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          when;
        string       name;
    } exp_t;

    exp_t sb[$];

    muldiv_wb_unit #(.WIDTH(32), .AW(5), .CW(6)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rd      (rd),
        .kill    (kill),
        .busy    (busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr got addr=%0d data=%h want no write", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_addr"}, 32'(wr_addr), 32'(e.addr));
                chk({e.name, "_data"}, wr_data, e.data);
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.when));
            end
        end
    end

    // Drives one start pulse; returns just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [4:0] r, input bit push, input logic [31:0] res,
                         input string name);
        exp_t e;
        @(posedge clk);
        #1;
        op = o; a = x; b = y; rd = r; start = 1'b1;
        if (push) begin
            e.addr = r; e.data = res; e.when = cyc + 34; e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, "_busy"}, 32'(busy), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; op = OP_MUL; a = '0; b = '0; rd = '0;
        idle(2);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        rst = 1'b0;

        issue(OP_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1, 32'h00000001, "mul_max"); idle(36);
        issue(OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 1, 32'hFFFFFFFE, "mulh_max"); idle(36);
        issue(OP_MULH, 32'h00010000, 32'h00010000, 5'd31, 1, 32'h00000001, "mulh_2p32"); idle(36);
        issue(OP_DIV,  32'd100, 32'd7, 5'd9, 1, 32'd14, "div_100_7"); idle(36);
        issue(OP_REM,  32'd100, 32'd7, 5'd9, 1, 32'd2, "rem_100_7"); idle(36);
        issue(OP_DIV,  32'h80000000, 32'd1, 5'd10, 1, 32'h80000000, "div_msb"); idle(36);
        issue(OP_DIV,  32'h12345678, 32'd0, 5'd11, 1, 32'hFFFFFFFF, "div_zero"); idle(36);
        issue(OP_REM,  32'h12345678, 32'd0, 5'd12, 1, 32'h12345678, "rem_zero"); idle(36);

        // Reset mid-RUN: no write for the aborted op, outputs cleared at once.
        issue(OP_MUL, 32'd7, 32'd6, 5'd3, 0, 32'd0, "mul_rst");
        idle(9);
        #1;
        rst = 1'b1;
        #2;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", wr_data, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(40);
        issue(OP_MUL, 32'd7, 32'd6, 5'd3, 1, 32'd42, "mul_after_rst"); idle(36);

        // start held high: the second op is taken only in the idle cycle after DONE.
        begin
            exp_t e;
            int t;
            @(posedge clk);
            #1;
            t = cyc;
            op = OP_MUL; a = 32'd3; b = 32'd5; rd = 5'd1; start = 1'b1;
            e.addr = 5'd1; e.data = 32'd15; e.when = t + 34; e.name = "held_first";
            sb.push_back(e);
            e.addr = 5'd2; e.data = 32'd10; e.when = t + 68; e.name = "held_second";
            sb.push_back(e);
            @(posedge clk);
            #1;
            op = OP_DIV; a = 32'd50; b = 32'd5; rd = 5'd2;
            idle(34);
            #1;
            start = 1'b0;
            chk("held_busy_second", 32'(busy), 32'd1);
            idle(36);
        end

        // Start pulses while busy (including in DONE) are dropped.
        issue(OP_REM, 32'd17, 32'd5, 5'd4, 1, 32'd2, "rem_drop");
        idle(5);
        #1;
        op = OP_MUL; a = 32'd9; b = 32'd9; rd = 5'd6; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(26);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        idle(40);

        // kill in RUN cycle 20: no write, idle on the next cycle.
        issue(OP_MULH, 32'd10, 32'd10, 5'd7, 0, 32'd0, "kill_run");
        idle(19);
        #1;
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_run_busy", 32'(busy), 32'd0);
        idle(40);

        // kill in DONE is ignored; also writes to address 0.
        issue(OP_DIV, 32'd1000, 32'd10, 5'd0, 1, 32'd100, "kill_done");
        idle(32);
        #1;
        chk("kill_done_in_done", 32'(busy), 32'd1);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        idle(40);

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
